// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing constants (640x480@60 and 800x600@60) and the
//            helper that sums the four timing segments into a line/frame total.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int c_VGA640_H_ACTIVE = 640;
    localparam int c_VGA640_H_FP     = 16;
    localparam int c_VGA640_H_SYNC   = 96;
    localparam int c_VGA640_H_BP     = 48;
    localparam int c_VGA640_V_ACTIVE = 480;
    localparam int c_VGA640_V_FP     = 10;
    localparam int c_VGA640_V_SYNC   = 2;
    localparam int c_VGA640_V_BP     = 33;
    localparam int c_VGA640_H_POL    = 0;
    localparam int c_VGA640_V_POL    = 0;

    // 800x600@60, 40 MHz pixel clock (positive sync pulses)
    localparam int c_VGA800_H_ACTIVE = 800;
    localparam int c_VGA800_H_FP     = 40;
    localparam int c_VGA800_H_SYNC   = 128;
    localparam int c_VGA800_H_BP     = 88;
    localparam int c_VGA800_V_ACTIVE = 600;
    localparam int c_VGA800_V_FP     = 1;
    localparam int c_VGA800_V_SYNC   = 4;
    localparam int c_VGA800_V_BP     = 23;
    localparam int c_VGA800_H_POL    = 1;
    localparam int c_VGA800_V_POL    = 1;

    // Total length of one axis period (pixels per line or lines per frame)
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One timing axis (horizontal or vertical). Counts 0..TOTAL-1 on
//            each i_Step and decodes wrap, sync and active from the count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int POL    = 0,
    parameter int W      = 11
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Step,
    output logic [W-1:0] o_Count,
    output logic         o_Wrap,
    output logic         o_Sync,
    output logic         o_Active
);

    localparam int c_TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Timing must fit the counter and every segment must exist
    if ((c_TOTAL > (1 << W)) || (ACTIVE <= 0) || (FP <= 0) ||
        (SYNC <= 0) || (BP <= 0)) begin : g_bad_timing
        $error("vga_axis_counter: invalid timing (zero segment or total exceeds 2^W)");
    end

    localparam logic [W-1:0] c_LAST       = W'(c_TOTAL - 1);
    localparam logic [W-1:0] c_ACTIVE     = W'(ACTIVE);
    localparam logic [W-1:0] c_SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] c_SYNC_END   = W'(ACTIVE + FP + SYNC - 1);
    localparam logic         c_ASSERTED   = (POL != 0);

    logic [W-1:0] r_Count;
    logic         w_InSync;

    // Position counter: advance on step, wrap after the last position
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Count <= '0;
        end else if (i_Step) begin
            if (r_Count == c_LAST) begin
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + 1'b1;
            end
        end
    end

    // Decode of the current count; the top registers these
    always_comb begin
        w_InSync = (r_Count >= c_SYNC_START) && (r_Count <= c_SYNC_END);
        o_Count  = r_Count;
        o_Wrap   = (r_Count == c_LAST);
        o_Sync   = w_InSync ? c_ASSERTED : ~c_ASSERTED;
        o_Active = (r_Count < c_ACTIVE);
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator with pixel-clock enable.
//            Registers position, sync, data-enable and line/frame strobes for
//            the pixel whose counters were present before each enabled edge.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = c_VGA640_H_ACTIVE,
    parameter int H_FP       = c_VGA640_H_FP,
    parameter int H_SYNC     = c_VGA640_H_SYNC,
    parameter int H_BP       = c_VGA640_H_BP,
    parameter int V_ACTIVE   = c_VGA640_V_ACTIVE,
    parameter int V_FP       = c_VGA640_V_FP,
    parameter int V_SYNC     = c_VGA640_V_SYNC,
    parameter int V_BP       = c_VGA640_V_BP,
    parameter int H_SYNC_POL = c_VGA640_H_POL,
    parameter int V_SYNC_POL = c_VGA640_V_POL,
    parameter int COORD_W    = 11
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_PixEn,
    output logic [COORD_W-1:0] o_HPos,
    output logic [COORD_W-1:0] o_VPos,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Active,
    output logic               o_LineStart,
    output logic               o_FrameStart
);

    // Idle (deasserted) sync levels
    localparam logic c_H_IDLE = (H_SYNC_POL == 0);
    localparam logic c_V_IDLE = (V_SYNC_POL == 0);

    logic [COORD_W-1:0] w_HCount;
    logic [COORD_W-1:0] w_VCount;
    logic               w_HWrap;
    logic               w_VWrap;
    logic               w_HSync;
    logic               w_VSync;
    logic               w_HActive;
    logic               w_VActive;
    logic               w_VStep;
    logic               w_unused;

    logic [COORD_W-1:0] r_HPos;
    logic [COORD_W-1:0] r_VPos;
    logic               r_HSync;
    logic               r_VSync;
    logic               r_Active;
    logic               r_LineStart;
    logic               r_FrameStart;

    // Lines advance only on the enabled pixel that ends a line
    assign w_VStep = i_PixEn & w_HWrap;

    // End-of-frame carry has no consumer in this block
    assign w_unused = w_VWrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL),
        .W      (COORD_W)
    ) u_h_axis (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Step   (i_PixEn),
        .o_Count  (w_HCount),
        .o_Wrap   (w_HWrap),
        .o_Sync   (w_HSync),
        .o_Active (w_HActive)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL),
        .W      (COORD_W)
    ) u_v_axis (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Step   (w_VStep),
        .o_Count  (w_VCount),
        .o_Wrap   (w_VWrap),
        .o_Sync   (w_VSync),
        .o_Active (w_VActive)
    );

    // Output registers: capture the decode of the current pixel on enabled edges
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_HPos       <= '0;
            r_VPos       <= '0;
            r_HSync      <= c_H_IDLE;
            r_VSync      <= c_V_IDLE;
            r_Active     <= 1'b0;
            r_LineStart  <= 1'b0;
            r_FrameStart <= 1'b0;
        end else if (i_PixEn) begin
            r_HPos       <= w_HCount;
            r_VPos       <= w_VCount;
            r_HSync      <= w_HSync;
            r_VSync      <= w_VSync;
            r_Active     <= w_HActive & w_VActive;
            r_LineStart  <= (w_HCount == '0);
            r_FrameStart <= (w_HCount == '0) && (w_VCount == '0);
        end
    end

    assign o_HPos       = r_HPos;
    assign o_VPos       = r_VPos;
    assign o_HSync      = r_HSync;
    assign o_VSync      = r_VSync;
    assign o_Active     = r_Active;
    assign o_LineStart  = r_LineStart;
    assign o_FrameStart = r_FrameStart;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. Three instances share the
//            clock, reset and pixel enable: default 640x480, a tiny 16x9 raster
//            with positive sync (total equal to 2^COORD_W), and 800x600 timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic i_Reset;
    logic i_PixEn;

    // Default 640x480 instance
    logic [10:0] a_h, a_v;
    logic        a_hs, a_vs, a_act, a_ls, a_fs;
    // Tiny instance: H 10/2/3/1 = 16, V 5/1/2/1 = 9, positive sync, 4-bit coords
    logic [3:0]  b_h, b_v;
    logic        b_hs, b_vs, b_act, b_ls, b_fs;
    // 800x600 instance
    logic [10:0] c_h, c_v;
    logic        c_hs, c_vs, c_act, c_ls, c_fs;

    int total;
    int bad;
    int k;          // enabled edges since the last reset
    bit started;

    vga_timing_gen u_dut_a (
        .i_Clk(clk), .i_Reset(i_Reset), .i_PixEn(i_PixEn),
        .o_HPos(a_h), .o_VPos(a_v), .o_HSync(a_hs), .o_VSync(a_vs),
        .o_Active(a_act), .o_LineStart(a_ls), .o_FrameStart(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(5),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .COORD_W(4)
    ) u_dut_b (
        .i_Clk(clk), .i_Reset(i_Reset), .i_PixEn(i_PixEn),
        .o_HPos(b_h), .o_VPos(b_v), .o_HSync(b_hs), .o_VSync(b_vs),
        .o_Active(b_act), .o_LineStart(b_ls), .o_FrameStart(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1),  .V_SYNC(4),   .V_BP(23),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .COORD_W(11)
    ) u_dut_c (
        .i_Clk(clk), .i_Reset(i_Reset), .i_PixEn(i_PixEn),
        .o_HPos(c_h), .o_VPos(c_v), .o_HSync(c_hs), .o_VSync(c_vs),
        .o_Active(c_act), .o_LineStart(c_ls), .o_FrameStart(c_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n enabled edges: the n-th edge shows raster pixel
    // (n-1) counted in line-major order; zero edges means the reset state.
    function automatic logic [28:0] model(input int n,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb,
                                          input int hp, input int vp);
        int   ht, vt, p, h, v;
        logic hsy, vsy;
        if (n == 0) begin
            return {12'd0, 12'd0, (hp == 0), (vp == 0), 3'b000};
        end
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        p   = (n - 1) % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        hsy = (h >= ha + hf && h < ha + hf + hs) ? (hp != 0) : (hp == 0);
        vsy = (v >= va + vf && v < va + vf + vs) ? (vp != 0) : (vp == 0);
        return {12'(h), 12'(v), hsy, vsy, (h < ha && v < va), (h == 0), (h == 0 && v == 0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Track enabled edges exactly as the DUT sees its inputs
    always @(posedge clk) begin
        if (i_Reset) begin
            k       = 0;
            started = 1'b1;
        end else if (i_PixEn) begin
            k = k + 1;
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (started) begin
            chk("model_a", {3'b0, 12'(a_h), 12'(a_v), a_hs, a_vs, a_act, a_ls, a_fs},
                {3'b0, model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0)});
            chk("model_b", {3'b0, 12'(b_h), 12'(b_v), b_hs, b_vs, b_act, b_ls, b_fs},
                {3'b0, model(k, 10, 2, 3, 1, 5, 1, 2, 1, 1, 1)});
            chk("model_c", {3'b0, 12'(c_h), 12'(c_v), c_hs, c_vs, c_act, c_ls, c_fs},
                {3'b0, model(k, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1)});
        end
    end

    initial begin
        int n_ls, n_fs, n_hs, n_vs;
        total   = 0;
        bad     = 0;
        k       = 0;
        started = 1'b0;
        i_Reset = 1'b1;
        i_PixEn = 1'b1;     // reset must win over the enable
        step(3);

        // Reset state (literals)
        chk("rst_a_hpos",  32'(a_h), 0);
        chk("rst_a_vpos",  32'(a_v), 0);
        chk("rst_a_hsync", 32'(a_hs), 1);
        chk("rst_a_vsync", 32'(a_vs), 1);
        chk("rst_a_flags", 32'({a_act, a_ls, a_fs}), 0);
        chk("rst_b_syncs", 32'({b_hs, b_vs}), 0);

        // Continuous enable from release
        i_Reset = 1'b0;
        step(1);    // k=1: pixel (0,0)
        chk("first_a_pos",   32'({a_h, a_v}), 0);
        chk("first_a_flags", 32'({a_hs, a_vs, a_act, a_ls, a_fs}), 32'b11111);
        step(640);  // k=641: pixel 640
        chk("a_h640_pos", 32'(a_h), 640);
        chk("a_h640_act", 32'(a_act), 0);
        step(15);   // k=656: pixel 655
        chk("a_h655_hs", 32'(a_hs), 1);
        step(1);    // k=657: pixel 656
        chk("a_h656_hs", 32'(a_hs), 0);
        step(95);   // k=752: pixel 751
        chk("a_h751_hs", 32'(a_hs), 0);
        step(1);    // k=753: pixel 752
        chk("a_h752_hs", 32'(a_hs), 1);
        step(46);   // k=799: pixel 798
        chk("a_h798_v", 32'({a_h, a_v}), 32'({11'd798, 11'd0}));
        step(2);    // k=801: pixel (0,1)
        chk("a_line1_pos", 32'({a_h, a_v}), 32'({11'd0, 11'd1}));
        chk("a_line1_str", 32'({a_ls, a_fs}), 32'b10);
        step(40);   // k=841: 800x600 pixel 840
        chk("c_h840_hs", 32'(c_hs), 1);
        step(128);  // k=969: 800x600 pixel 968
        chk("c_h968_hs", 32'(c_hs), 0);
        step(1300);

        // Half-rate pixel enable
        for (int i = 0; i < 2000; i++) begin
            i_PixEn = (i % 2 == 0);
            step(1);
        end

        // Fresh frame; drive the tiny raster into both sync pulses
        i_PixEn = 1'b1;
        i_Reset = 1'b1;
        step(1);
        i_Reset = 1'b0;
        step(110);  // k=110: tiny pixel 109 = (13,6)
        chk("b_sync_pos", 32'({b_h, b_v}), 32'({4'd13, 4'd6}));
        chk("b_sync_lv",  32'({b_hs, b_vs}), 32'b11);
        i_Reset = 1'b1;
        step(1);
        chk("b_cut_sync", 32'({b_hs, b_vs}), 32'b00);
        chk("b_cut_pos",  32'({b_h, b_v, b_act}), 0);
        i_Reset = 1'b0;
        step(1);
        chk("b_restart",  32'({b_h, b_v, b_ls, b_fs}), 32'b11);

        // One whole tiny frame: strobe and sync-pulse counts
        n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0;
        for (int i = 0; i < 144; i++) begin
            step(1);
            n_ls += int'(b_ls);
            n_fs += int'(b_fs);
            n_hs += int'(b_hs);
            n_vs += int'(b_vs);
        end
        chk("b_frame_ls", 32'(n_ls), 9);
        chk("b_frame_fs", 32'(n_fs), 1);
        chk("b_frame_hs", 32'(n_hs), 27);
        chk("b_frame_vs", 32'(n_vs), 32);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and successor to the fixed 800x525 sweep counter.
- Horizontal and vertical timing are built from active, front-porch, sync and back-porch lengths, with programmable sync polarity and a pixel-clock enable so it can run from a faster system clock.
- Outputs are the registered pixel position, sync pulses, a data-enable flag and line/frame start strobes.
- Feeds the maze renderer and the colour output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
- V_SYNC_POL, 0, asserted level of o_VSync
- COORD_W, 11, width of position counters/outputs

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  synchronous, active-high reset
- i_PixEn  input  1  pixel-clock enable; one pixel advances per i_Clk with i_PixEn=1
- o_HPos  output  COORD_W  horizontal position of current pixel, 0..H_TOTAL-1
- o_VPos  output  COORD_W  vertical position of current line, 0..V_TOTAL-1
- o_HSync  output  1  horizontal sync, polarity per H_SYNC_POL
- o_VSync  output  1  vertical sync, polarity per V_SYNC_POL
- o_Active  output  1  high when o_HPos<H_ACTIVE and o_VPos<V_ACTIVE
- o_LineStart  output  1  one-pixel strobe when o_HPos=0
- o_FrameStart  output  1  one-pixel strobe when o_HPos=0 and o_VPos=0

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2^COORD_W, or any length is 0.
- Internal counters h_cnt and v_cnt; all outputs registered.
- Each i_Clk edge with i_Reset=0 and i_PixEn=1:
  - outputs <= decode(h_cnt, v_cnt)
  - h_cnt advances; when h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt advances
  - v_cnt wraps to 0 after V_TOTAL-1 (wrapping only when h_cnt also wraps)
- Latency: outputs describe the pixel whose counter value was present before the enabled edge. The first enabled edge after reset presents (0,0).
- Decode rules:
  - HSync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - VSync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491; asserted for whole lines, HSync-independent
  - Deasserted level = ~POL
- i_PixEn=0: counters and all outputs hold, strobes included. Each strobe is valid for exactly one enabled pixel period; the sink samples it qualified by i_PixEn.
- Reset (has priority over i_PixEn, any time, including mid-line or mid-sync):
  - h_cnt=0, v_cnt=0, o_HPos=0, o_VPos=0
  - o_Active=0, o_LineStart=0, o_FrameStart=0
  - o_HSync=~H_SYNC_POL, o_VSync=~V_SYNC_POL
- Reset asserted during a sync pulse cuts the pulse short the next cycle. No partial-frame recovery; the new frame starts at (0,0).
- No combinational path from input to output.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants for 640x480@60 (the defaults above)
  - a second 800x600 set for future modes
  - H_TOTAL/V_TOTAL helper functions
- One natural sub-module, vga_axis_counter, used twice (horizontal, vertical):
  - parameters ACTIVE, FP, SYNC, BP, POL, W
  - inputs i_Clk, i_Reset, i_Step
  - outputs count, wrap, sync, active
- Vertical instance i_Step = i_PixEn & horizontal wrap.

Test Plan:
- Defaults, i_PixEn=1 constantly, release reset -> o_HPos goes 0,1,...,799,0 and o_VPos increments on the 799->0 transition; 420000 cycles per frame; o_FrameStart high exactly once per frame at (0,0).
- Horizontal sync check, defaults -> o_HSync=0 exactly for o_HPos 656..751 (96 pixels) on every line; o_Active=0 for o_HPos>=640 and for o_VPos>=480.
- Vertical sync check -> o_VSync=0 for all pixels of lines 490 and 491 only (1600 enabled cycles); o_LineStart pulses 525 times per frame.
- i_PixEn toggling 1-of-2 (25 MHz pixel from 50 MHz clock) -> all outputs hold on disabled cycles; sequence identical to the always-enabled run at half rate.
- Assert i_Reset for 1 cycle at (700,491), inside both sync pulses -> next cycle syncs deasserted (1), positions 0, o_Active=0; first enabled edge afterwards gives (0,0), o_FrameStart=1.
- Override H_SYNC_POL=1, V_SYNC_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23 -> H_TOTAL=1056, V_TOTAL=628; o_HSync=1 only for h 840..967, o_VSync=1 only for lines 601..604.
